// File: rtl/operand_fetch_stage_if.sv
// Decode->execute operand-fetch bundle: decoded instruction in, GPR read port, EX/WB bypass, operand slot out.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the decode side, out_valid/out_ready on the EX side.
interface operand_fetch_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Control
    logic            flush;

    // Decoded instruction input
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic            in_use_rs1;
    logic            in_use_rs2;
    logic [AW-1:0]   in_rd;
    logic            in_rd_we;
    logic            in_is_load;
    logic [7:0]      in_ctrl;

    // GPR file read port
    logic [AW-1:0]   rf_addr_1;
    logic [AW-1:0]   rf_addr_2;
    logic [XLEN-1:0] rf_data_1;
    logic [XLEN-1:0] rf_data_2;

    // EX-stage bypass
    logic            ex_valid;
    logic            ex_rd_we;
    logic            ex_is_load;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_data;

    // WB-stage bypass
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    // Operand slot output
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [AW-1:0]   out_rd;
    logic            out_rd_we;
    logic            out_is_load;
    logic [7:0]      out_ctrl;

    // Operand-fetch stage view
    modport slave (
        input  flush,
        input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
        input  in_rd, in_rd_we, in_is_load, in_ctrl,
        output in_ready,
        output rf_addr_1, rf_addr_2,
        input  rf_data_1, rf_data_2,
        input  ex_valid, ex_rd_we, ex_is_load, ex_rd, ex_data,
        input  wb_we, wb_rd, wb_data,
        output out_valid, out_pc, out_imm, out_op1, out_op2,
        output out_rd, out_rd_we, out_is_load, out_ctrl,
        input  out_ready
    );

    // Surrounding pipeline view
    modport master (
        output flush,
        output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
        output in_rd, in_rd_we, in_is_load, in_ctrl,
        input  in_ready,
        input  rf_addr_1, rf_addr_2,
        output rf_data_1, rf_data_2,
        output ex_valid, ex_rd_we, ex_is_load, ex_rd, ex_data,
        output wb_we, wb_rd, wb_data,
        input  out_valid, out_pc, out_imm, out_op1, out_op2,
        input  out_rd, out_rd_we, out_is_load, out_ctrl,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode->execute stage: reads GPRs, bypasses EX/WB results, stalls on load-use, holds one operand slot.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops on flush, load-use hazard, or a full slot that EX is not draining.
module operand_fetch_stage #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input logic                clk,
    input logic                rst,
    operand_fetch_stage_if.slave ofs
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [AW-1:0]   rd;
        logic            rd_we;
        logic            is_load;
        logic [7:0]      ctrl;
    } slot_t;

    state_e          state_q, state_d;
    slot_t           slot_q, slot_d;

    logic            ex_wr;
    logic            ex_hit_1;
    logic            ex_hit_2;
    logic            hazard;
    logic            ex_fwd;
    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // Bypass priority: x0 is hardwired zero, then EX, then WB (which also covers
    // the GPR being written in the same cycle it is read), then the GPR file.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [AW-1:0]   idx,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_ok,
        input logic [AW-1:0]   ex_idx,
        input logic [XLEN-1:0] ex_val,
        input logic            wb_ok,
        input logic [AW-1:0]   wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] res;
        res = rf_val;
        if (idx == '0) begin
            res = '0;
        end else if (ex_ok && (ex_idx == idx)) begin
            res = ex_val;
        end else if (wb_ok && (wb_idx == idx)) begin
            res = wb_val;
        end
        return res;
    endfunction

    // Hazard detection: an EX producer that cannot be bypassed (a load, or any
    // producer when EX bypass is disabled) blocks a consumer of the same register.
    always_comb begin
        ex_wr    = ofs.ex_valid & ofs.ex_rd_we & (ofs.ex_rd != '0);
        ex_hit_1 = ofs.in_use_rs1 & (ofs.ex_rd == ofs.in_rs1);
        ex_hit_2 = ofs.in_use_rs2 & (ofs.ex_rd == ofs.in_rs2);
        hazard   = ex_wr & (ex_hit_1 | ex_hit_2) & (ofs.ex_is_load | !FWD_EN);
        ex_fwd   = ofs.ex_valid & ofs.ex_rd_we & !ofs.ex_is_load & FWD_EN;
        in_ready = !ofs.flush & !hazard & ((state_q == EMPTY) | ofs.out_ready);
        accept   = ofs.in_valid & in_ready;
    end

    // Operand selection for both sources, sampled into the slot only on accept.
    always_comb begin
        op1 = pick_operand(ofs.in_rs1, ofs.rf_data_1, ex_fwd, ofs.ex_rd, ofs.ex_data,
                           ofs.wb_we, ofs.wb_rd, ofs.wb_data);
        op2 = pick_operand(ofs.in_rs2, ofs.rf_data_2, ex_fwd, ofs.ex_rd, ofs.ex_data,
                           ofs.wb_we, ofs.wb_rd, ofs.wb_data);
    end

    // Next-state and slot load: flush beats accept; a held slot never re-samples.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (ofs.flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d       = FULL;
            slot_d.pc     = ofs.in_pc;
            slot_d.imm    = ofs.in_imm;
            slot_d.op1    = op1;
            slot_d.op2    = op2;
            slot_d.rd     = ofs.in_rd;
            slot_d.rd_we  = ofs.in_rd_we;
            slot_d.is_load = ofs.in_is_load;
            slot_d.ctrl   = ofs.in_ctrl;
        end else if ((state_q == FULL) && ofs.out_ready) begin
            state_d = EMPTY;
        end
    end

    // State and slot registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    assign ofs.in_ready    = in_ready;
    assign ofs.rf_addr_1   = ofs.in_rs1;
    assign ofs.rf_addr_2   = ofs.in_rs2;
    assign ofs.out_valid   = (state_q == FULL);
    assign ofs.out_pc      = slot_q.pc;
    assign ofs.out_imm     = slot_q.imm;
    assign ofs.out_op1     = slot_q.op1;
    assign ofs.out_op2     = slot_q.op2;
    assign ofs.out_rd      = slot_q.rd;
    assign ofs.out_rd_we   = slot_q.rd_we;
    assign ofs.out_is_load = slot_q.is_load;
    assign ofs.out_ctrl    = slot_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: scoreboard on the output slot plus directed checks.
// Latency: expects accepted instructions in the slot one edge after acceptance.
// Backpressure: exercises hazard stalls, held slots, back-to-back transfer and flush.
module tb_operand_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic [7:0]  ctrl;
    } exp_t;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;
    exp_t        sb[$];
    logic [31:0] gpr [32];

    operand_fetch_stage_if #(.XLEN(32), .AW(5)) ofif ();

    operand_fetch_stage #(.XLEN(32), .AW(5), .FWD_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .ofs (ofif)
    );

    assign ofif.rf_data_1 = gpr[ofif.rf_addr_1];
    assign ofif.rf_data_2 = gpr[ofif.rf_addr_2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_op(input logic [4:0] idx);
        logic [31:0] r;
        r = gpr[idx];
        if (idx == 5'd0) r = 32'h0;
        else if (ofif.ex_valid && ofif.ex_rd_we && !ofif.ex_is_load && ofif.ex_rd == idx) r = ofif.ex_data;
        else if (ofif.wb_we && ofif.wb_rd == idx) r = ofif.wb_data;
        return r;
    endfunction

    // Scoreboard monitor: inputs are stable at the falling edge, so handshakes seen here
    // are the ones the next rising edge will perform.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst) begin
            if (ofif.flush) begin
                if (ofif.out_valid && sb.size() > 0) sb.delete(0);
            end else begin
                if (ofif.out_valid && ofif.out_ready) begin
                    got.pc = ofif.out_pc;   got.imm = ofif.out_imm;
                    got.op1 = ofif.out_op1; got.op2 = ofif.out_op2;
                    got.rd = ofif.out_rd;   got.rd_we = ofif.out_rd_we;
                    got.is_load = ofif.out_is_load; got.ctrl = ofif.out_ctrl;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: got pc=%h, required no output", got.pc);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL sb_slot: got pc=%h op1=%h op2=%h rd=%0d ctrl=%h, required pc=%h op1=%h op2=%h rd=%0d ctrl=%h",
                                     got.pc, got.op1, got.op2, got.rd, got.ctrl, e.pc, e.op1, e.op2, e.rd, e.ctrl);
                        end
                    end
                end
                if (ofif.in_valid && ofif.in_ready) begin
                    e.pc = ofif.in_pc;   e.imm = ofif.in_imm;
                    e.op1 = exp_op(ofif.in_rs1);
                    e.op2 = exp_op(ofif.in_rs2);
                    e.rd = ofif.in_rd;   e.rd_we = ofif.in_rd_we;
                    e.is_load = ofif.in_is_load; e.ctrl = ofif.in_ctrl;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ofif.flush = 0;      ofif.in_valid = 0;
        ofif.in_pc = 0;      ofif.in_imm = 0;
        ofif.in_rs1 = 0;     ofif.in_rs2 = 0;
        ofif.in_use_rs1 = 0; ofif.in_use_rs2 = 0;
        ofif.in_rd = 0;      ofif.in_rd_we = 0;
        ofif.in_is_load = 0; ofif.in_ctrl = 0;
        ofif.ex_valid = 0;   ofif.ex_rd_we = 0; ofif.ex_is_load = 0;
        ofif.ex_rd = 0;      ofif.ex_data = 0;
        ofif.wb_we = 0;      ofif.wb_rd = 0;    ofif.wb_data = 0;
        ofif.out_ready = 1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
        ofif.in_valid = 1;     ofif.in_pc = pc;  ofif.in_imm = pc ^ 32'hFFFF_0000;
        ofif.in_rs1 = rs1;     ofif.in_use_rs1 = u1;
        ofif.in_rs2 = rs2;     ofif.in_use_rs2 = u2;
        ofif.in_rd = rd;       ofif.in_rd_we = (rd != 0);
        ofif.in_is_load = pc[2]; ofif.in_ctrl = pc[11:4];
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        step();
        checks++;
        if ({ofif.out_valid, ofif.out_pc, ofif.out_imm, ofif.out_op1, ofif.out_op2, ofif.out_rd,
             ofif.out_rd_we, ofif.out_is_load, ofif.out_ctrl} !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b pc=%h op1=%h, required all zero",
                     ofif.out_valid, ofif.out_pc, ofif.out_op1);
        end
        rst = 1;
        step();
        // Mid-transfer reset: fill the slot, then pull reset between edges.
        gpr[2] = 32'h22;
        ofif.out_ready = 0;
        drive(32'h100, 5'd2, 1, 5'd0, 0, 5'd1);
        step();
        ofif.in_valid = 0;
        #1 rst = 0;
        #1;
        checks++;
        if (ofif.out_valid !== 1'b0 || ofif.out_op1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: got valid=%b op1=%h, required valid=0 op1=0",
                     ofif.out_valid, ofif.out_op1);
        end
        sb.delete();
        step();
        rst = 1;
        #1;
        checks++;
        if (ofif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, required 1", ofif.in_ready);
        end
        ofif.out_ready = 1;
        step();
    endtask

    task automatic test_basic();
        gpr[3] = 32'h11;
        drive(32'h200, 5'd3, 1, 5'd4, 0, 5'd6);
        #1;
        checks++;
        if (ofif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_in_ready: got %b, required 1", ofif.in_ready);
        end
        step();
        ofif.in_valid = 0;
        checks++;
        if (ofif.out_valid !== 1'b1 || ofif.out_op1 !== 32'h11) begin
            failures++;
            $display("FAIL basic_slot: got valid=%b op1=%h, required valid=1 op1=00000011",
                     ofif.out_valid, ofif.out_op1);
        end
        step();
        checks++;
        if (ofif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain: got valid=%b, required 0", ofif.out_valid);
        end
    endtask

    task automatic test_forward();
        gpr[5] = 32'h5555;
        gpr[0] = 32'hDEAD_0000;
        ofif.ex_valid = 1; ofif.ex_rd_we = 1; ofif.ex_rd = 5; ofif.ex_data = 32'hAAAA;
        ofif.wb_we = 1;    ofif.wb_rd = 5;    ofif.wb_data = 32'hBBBB;
        drive(32'h300, 5'd0, 0, 5'd5, 1, 5'd8);
        step();
        checks++;
        if (ofif.out_op2 !== 32'hAAAA) begin
            failures++;
            $display("FAIL fwd_ex_wins: got %h, required 0000aaaa", ofif.out_op2);
        end
        drive(32'h310, 5'd0, 1, 5'd0, 1, 5'd8);
        step();
        checks++;
        if (ofif.out_op2 !== 32'h0 || ofif.out_op1 !== 32'h0) begin
            failures++;
            $display("FAIL fwd_x0: got op1=%h op2=%h, required 0 and 0", ofif.out_op1, ofif.out_op2);
        end
        ofif.ex_valid = 0;
        drive(32'h320, 5'd5, 1, 5'd5, 1, 5'd8);
        step();
        checks++;
        if (ofif.out_op2 !== 32'hBBBB || ofif.out_op1 !== 32'hBBBB) begin
            failures++;
            $display("FAIL fwd_wb: got op1=%h op2=%h, required 0000bbbb", ofif.out_op1, ofif.out_op2);
        end
        ofif.wb_we = 0;
        drive(32'h330, 5'd3, 1, 5'd5, 1, 5'd8);
        step();
        checks++;
        if (ofif.out_op2 !== 32'h5555) begin
            failures++;
            $display("FAIL fwd_rf: got %h, required 00005555", ofif.out_op2);
        end
        ofif.in_valid = 0;
        step();
    endtask

    task automatic test_load_use();
        gpr[7] = 32'h7777;
        ofif.ex_valid = 1; ofif.ex_rd_we = 1; ofif.ex_is_load = 1; ofif.ex_rd = 0; ofif.ex_data = 32'h9999;
        ofif.in_valid = 0; ofif.in_rs1 = 0; ofif.in_use_rs1 = 1;
        #1;
        checks++;
        if (ofif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lu_x0_no_stall: got %b, required 1", ofif.in_ready);
        end
        ofif.ex_rd = 7; ofif.in_rs1 = 7; ofif.in_use_rs1 = 0;
        #1;
        checks++;
        if (ofif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lu_unused_no_stall: got %b, required 1", ofif.in_ready);
        end
        drive(32'h400, 5'd7, 1, 5'd0, 0, 5'd9);
        #1;
        checks++;
        if (ofif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL lu_stall: got in_ready=%b, required 0", ofif.in_ready);
        end
        step();
        checks++;
        if (ofif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble: got out_valid=%b, required 0", ofif.out_valid);
        end
        ofif.ex_valid = 0; ofif.ex_is_load = 0;
        ofif.wb_we = 1; ofif.wb_rd = 7; ofif.wb_data = 32'h1234;
        #1;
        checks++;
        if (ofif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lu_release: got in_ready=%b, required 1", ofif.in_ready);
        end
        step();
        ofif.in_valid = 0; ofif.wb_we = 0;
        checks++;
        if (ofif.out_valid !== 1'b1 || ofif.out_op1 !== 32'h1234) begin
            failures++;
            $display("FAIL lu_wb_fwd: got valid=%b op1=%h, required valid=1 op1=00001234",
                     ofif.out_valid, ofif.out_op1);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] snap;
        ofif.out_ready = 0;
        drive(32'h500, 5'd3, 1, 5'd5, 1, 5'd10);
        step();
        snap = {ofif.out_pc, ofif.out_imm, ofif.out_op1, ofif.out_op2};
        drive(32'h504, 5'd5, 1, 5'd3, 1, 5'd11);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ofif.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_in_ready[%0d]: got %b, required 0", i, ofif.in_ready);
            end
            step();
            checks++;
            if (ofif.out_valid !== 1'b1 || {ofif.out_pc, ofif.out_imm, ofif.out_op1, ofif.out_op2} !== snap) begin
                failures++;
                $display("FAIL hold_stable[%0d]: got valid=%b pc=%h, required valid=1 pc=%h",
                         i, ofif.out_valid, ofif.out_pc, snap[127:96]);
            end
        end
        ofif.out_ready = 1;
        step();
        checks++;
        if (ofif.out_valid !== 1'b1 || ofif.out_pc !== 32'h504) begin
            failures++;
            $display("FAIL b2b_first: got valid=%b pc=%h, required valid=1 pc=00000504",
                     ofif.out_valid, ofif.out_pc);
        end
        drive(32'h508, 5'd7, 1, 5'd2, 1, 5'd12);
        step();
        ofif.in_valid = 0;
        checks++;
        if (ofif.out_valid !== 1'b1 || ofif.out_pc !== 32'h508) begin
            failures++;
            $display("FAIL b2b_second: got valid=%b pc=%h, required valid=1 pc=00000508",
                     ofif.out_valid, ofif.out_pc);
        end
        step();
    endtask

    task automatic test_flush();
        ofif.out_ready = 0;
        drive(32'h600, 5'd3, 1, 5'd0, 0, 5'd13);
        step();
        drive(32'hDEAD_0600, 5'd2, 1, 5'd0, 0, 5'd14);
        ofif.flush = 1;
        #1;
        checks++;
        if (ofif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_ready: got %b, required 0", ofif.in_ready);
        end
        step();
        ofif.flush = 0; ofif.in_valid = 0;
        checks++;
        if (ofif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill: got out_valid=%b, required 0", ofif.out_valid);
        end
        ofif.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ofif.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost[%0d]: got out_valid=%b pc=%h, required 0",
                         i, ofif.out_valid, ofif.out_pc);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) gpr[i] = 32'h1000 + i;
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_flush();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
